// File: rtl/slow_clock_monitor.sv
// Slow clock monitor: synchronizes slow_in, emits edge enables, measures half-periods and tracks lock.
// Define SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN to add a FILT_LEN-cycle glitch filter on the synchronized input.
module slow_clock_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 12,
    parameter int EXP_HALF    = 450,
    parameter int TOL         = 4,
    parameter int LOCK_COUNT  = 4
`ifdef SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN
    , parameter int FILT_LEN  = 3
`endif
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             slow_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] MATCH_LO   = CNT_W'(EXP_HALF - TOL);
    localparam logic [CNT_W-1:0] MATCH_HI   = CNT_W'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(EXP_HALF + TOL + 1);
    localparam int               MC_W       = $clog2(LOCK_COUNT + 1);
`ifdef SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN
    localparam int               PRIME_LEN  = SYNC_STAGES + 2;
`else
    localparam int               PRIME_LEN  = SYNC_STAGES + 1;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic [PRIME_LEN-1:0]   prime_q;
    logic                   primed;
    logic                   synced;
    logic                   acc_lvl;
    logic                   level_q;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   edge_seen;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_sat_inc;
    logic                   is_match;
    logic                   timeout;
    state_e                 state_q, state_d;
    logic [MC_W-1:0]        match_q, match_d;
    logic                   pv_q, pv_d;
    logic [CNT_W-1:0]       half_q, half_d;
    logic                   err_q, err_d;

    assign synced = sync_q[SYNC_STAGES-1];
    // Edge detection stays off until the chain and level copy hold post-reset samples,
    // so a level that changed during reset never produces a pulse.
    assign primed = prime_q[PRIME_LEN-1];

`ifdef SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic            acc_q, acc_d;
    logic [FC_W-1:0] filt_q, filt_d;

    always_comb begin
        acc_d  = acc_q;
        filt_d = '0;
        if (!primed) begin
            acc_d = synced;
        end else if (synced != acc_q) begin
            if (filt_q == FC_W'(FILT_LEN - 1)) acc_d = synced;
            else                                filt_d = filt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= 1'b0;
            filt_q <= '0;
        end else begin
            acc_q  <= acc_d;
            filt_q <= filt_d;
        end
    end

    assign acc_lvl = acc_q;
`else
    assign acc_lvl = synced;
`endif

    assign rise_d    = primed &  acc_lvl & ~level_q;
    assign fall_d    = primed & ~acc_lvl &  level_q;
    assign edge_seen = rise_q | fall_q;

    assign cnt_sat_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    assign is_match    = (cnt_sat_inc >= MATCH_LO) && (cnt_sat_inc <= MATCH_HI);
    // An edge in the threshold cycle wins: timeout only counts when no edge is present.
    assign timeout     = !edge_seen && (state_q != SEARCH) && (cnt_q == TIMEOUT_AT);
    assign cnt_d       = (edge_seen || timeout) ? '0 : cnt_sat_inc;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        state_d = state_q;
        match_d = match_q;
        pv_d    = 1'b0;
        half_d  = half_q;
        err_d   = err_q;
        case (state_q)
            SEARCH: begin
                if (edge_seen) begin
                    state_d = ACQUIRE;
                    match_d = '0;
                end
            end
            ACQUIRE: begin
                if (edge_seen) begin
                    pv_d   = 1'b1;
                    half_d = cnt_sat_inc;
                    if (!is_match) begin
                        match_d = '0;
                    end else if (match_q == MC_W'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        match_d = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d = SEARCH;
                    match_d = '0;
                end
            end
            LOCKED: begin
                if (edge_seen) begin
                    pv_d   = 1'b1;
                    half_d = cnt_sat_inc;
                    if (!is_match) begin
                        state_d = LOST;
                        err_d   = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = LOST;
                    err_d   = 1'b1;
                end
            end
            LOST: begin
                if (edge_seen) begin
                    pv_d    = 1'b1;
                    half_d  = cnt_sat_inc;
                    state_d = ACQUIRE;
                    match_d = '0;
                end else if (timeout) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prime_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= SEARCH;
            match_q <= '0;
            pv_q    <= 1'b0;
            half_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from before the edge.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_in};
            prime_q <= {prime_q[PRIME_LEN-2:0], 1'b1};
            level_q <= acc_lvl;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            match_q <= match_d;
            pv_q    <= pv_d;
            half_q  <= half_d;
            err_q   <= err_d;
        end
    end

    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign half_period  = half_q;
    assign period_valid = pv_q;
    assign locked       = (state_q == LOCKED);
    assign timeout_err  = err_q;

endmodule

// File: doc/slow_clock_monitor.md
Name: slow_clock_monitor

Overview:
Receive-side companion to the slow clock divider. Takes a slow toggling clock-like signal (asynchronous to clk_in) and synchronizes it. Emits single-cycle rise/fall enable pulses in the clk_in domain and measures each half-period in clk_in cycles. A lock FSM reports whether the input matches the expected toggle rate (nominal 450 cycles per half-period), so downstream quiz logic can use clean enables instead of clocking on the slow signal.

Parameters:
SYNC_STAGES, 2, synchronizer flop count on slow_in (legal ≥2)
CNT_W, 12, half-period counter / measurement width
EXP_HALF, 450, expected half-period in clk_in cycles
TOL, 4, accepted deviation: measurement in [EXP_HALF-TOL, EXP_HALF+TOL] is a match
LOCK_COUNT, 4, consecutive matches required to declare lock
FILT_LEN, 3, glitch filter length (used only with the optional feature)

Ports:
clk_in  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
slow_in  input  1  asynchronous slow toggling input
rise_pulse  output  1  one-cycle pulse per accepted rising edge
fall_pulse  output  1  one-cycle pulse per accepted falling edge
half_period  output  CNT_W  last measured half-period, in cycles between consecutive edge pulses
period_valid  output  1  one-cycle strobe when half_period updates
locked  output  1  high in state LOCKED
timeout_err  output  1  sticky; set on any loss of lock, cleared only by reset

Behaviour:
- Reset (reset_n=0, asynchronous): sync chain, level register, counter and match count cleared to 0. State is SEARCH. All outputs 0, including half_period.
- Sync/edge: slow_in passes through SYNC_STAGES flops. The accepted level is compared with its registered copy, and the edge pulses are registered.
- Edge latency: a pulse appears exactly SYNC_STAGES+1 clk_in edges after the first edge that samples the new level. Pulse width is exactly 1 cycle.
- Counter:
  - Cleared to 0 on an edge-pulse cycle; otherwise increments.
  - Saturates at 2^CNT_W-1 with no wrap.
  - On an edge, measurement = counter+1, saturating.
- period_valid/half_period:
  - Update on every edge except the first edge after entering SEARCH, which has no reference.
  - half_period holds its value between updates.
- Match: TOL ≤ |measurement - EXP_HALF|+... precisely, measurement within EXP_HALF±TOL, inclusive bounds.
- Timeout: counter reaches EXP_HALF+TOL+1 with no edge.
- FSM:
  - SEARCH: first edge -> ACQUIRE, match count 0.
  - ACQUIRE, edge with match: match count +1. Reaching LOCK_COUNT -> LOCKED.
  - ACQUIRE, edge with mismatch: match count -> 0, stay in ACQUIRE.
  - ACQUIRE, timeout -> SEARCH.
  - LOCKED: mismatch or timeout -> LOST and set timeout_err.
  - LOST: next edge -> ACQUIRE with match count 0; that edge serves as the reference. Timeout -> SEARCH.
- Simultaneous events: an edge and the timeout threshold in the same cycle -> the edge wins and the measurement is evaluated normally.
- locked rises in the same cycle as the period_valid strobe that completes lock. It falls the cycle after the failing event.
- Reset mid-operation: immediate return to SEARCH. Any in-flight edge is discarded; no pulse after reset deasserts unless a fresh level change is synchronized.

Optional Feature:
- Macro: SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN.
- Defined: the accepted level changes only after the synchronized value has differed from it for FILT_LEN consecutive cycles. Shorter runs are ignored and the filter counter restarts.
  - Edge latency becomes SYNC_STAGES+FILT_LEN+1.
  - Measurements are unaffected for clean inputs.
- Undefined: the accepted level is the synchronized value directly; no filter logic is present.

Test Plan:
- Reset: hold reset_n=0 with slow_in toggling -> all outputs 0. After release with slow_in static for 1000 cycles -> state SEARCH, no pulses, timeout_err=0.
- Nominal lock: toggle slow_in every 450 cycles -> rise/fall pulses alternate, each 1 cycle wide, at latency 3.
  - First edge: no period_valid.
  - Following edges: half_period=450.
  - locked=1 on the 5th edge, i.e. the 4th measurement.
- Tolerance: after lock, half-periods of 446 and 454 -> stays locked. A half-period of 455 -> locked=0 next cycle, timeout_err=1, state LOST. Nominal toggling resumed -> relock after 4 matches; timeout_err stays 1.
- Stall: after lock, stop toggling -> timeout at counter=455, locked drops, state LOST. A further 455 cycles without an edge -> SEARCH.
- Mid-lock reset: pulse reset_n low for 2 cycles while locked -> outputs clear asynchronously, including timeout_err. Next edge gives no period_valid.
- Glitch (macro defined, FILT_LEN=3): 2-cycle high glitch on a low slow_in -> no rise_pulse. A 3-cycle-stable transition -> rise_pulse at latency 6.
